// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status bundle for the UART transmitter with its byte FIFO.
// The master drives bytes in; the slave (the transmitter) reports FIFO status and the serial line.
interface uart_tx_fifo_if #(
   parameter int CNT_W = 3
);
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             full;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;
   logic             busy;
   logic             tx;

   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  fifo_count,
      input  overflow,
      input  busy,
      input  tx
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output fifo_count,
      output overflow,
      output busy,
      output tx
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; drives the usb_tx serial line.
// Frames go out back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 3
) (
   input  logic         clk,
   input  logic         reset,
   uart_tx_fifo_if.slave bus
);

   localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [AW-1:0]     PTR_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0]     PTR_ONE   = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } state_e;

   logic [7:0]        mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic              full_r;
   logic              overflow_r;
   logic              push_s;
   logic              pop_s;
   logic              empty_s;

   state_e            state_r;
   state_e            state_next_s;
   logic [BAUD_W-1:0] baud_r;
   logic [BAUD_W-1:0] baud_next_s;
   logic              wrap_s;
   logic [2:0]        idx_r;
   logic [2:0]        idx_next_s;
   logic [7:0]        shift_r;
   logic [7:0]        shift_next_s;
   logic              tx_r;
   logic              tx_next_s;
   logic              busy_r;
   logic              busy_next_s;

   // A push is only accepted while not full, even if a pop frees a slot on the same edge.
   assign push_s  = bus.wr_en & ~full_r;
   assign empty_s = (count_r == CNT_ZERO);
   assign wrap_s  = (baud_r == BAUD_LAST);

   // Occupancy after this edge's push and pop.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // FIFO byte storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= bus.wr_data;
      end
   end

   // FIFO pointers, occupancy, full flag and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == CNT_FULL);
         if (bus.wr_en && full_r) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Serialiser state register: FSM state, baud counter, bit index, shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         baud_r  <= BAUD_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
      end else begin
         state_r <= state_next_s;
         baud_r  <= baud_next_s;
         idx_r   <= idx_next_s;
         shift_r <= shift_next_s;
      end
   end

   // Next-state logic; bit boundaries happen only when the baud counter wraps.
   always_comb begin
      state_next_s = state_r;
      baud_next_s  = baud_r;
      idx_next_s   = idx_r;
      pop_s        = 1'b0;
      shift_next_s = shift_r;
      case (state_r)
         ST_IDLE: begin
            baud_next_s = BAUD_ZERO;
            idx_next_s  = 3'd0;
            if (!empty_s) begin
               state_next_s = ST_START;
               pop_s        = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (wrap_s) begin
               state_next_s = ST_DATA;
               baud_next_s  = BAUD_ZERO;
               idx_next_s   = 3'd0;
            end else begin
               baud_next_s = baud_r + BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (wrap_s) begin
               baud_next_s = BAUD_ZERO;
               if (idx_r == 3'd7) begin
                  state_next_s = ST_STOP;
                  idx_next_s   = 3'd0;
               end else begin
                  idx_next_s = idx_r + 3'd1;
               end
            end else begin
               baud_next_s = baud_r + BAUD_ONE;
            end
         end
         ST_STOP: begin
            if (wrap_s) begin
               baud_next_s = BAUD_ZERO;
               if (!empty_s) begin
                  state_next_s = ST_START;
                  pop_s        = 1'b1;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               baud_next_s = baud_r + BAUD_ONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            baud_next_s  = BAUD_ZERO;
            idx_next_s   = 3'd0;
         end
      endcase
      if (pop_s) begin
         shift_next_s = mem_r[rd_ptr_r];
      end else begin
         shift_next_s = shift_r;
      end
   end

   // Line level and busy for the state being entered, so the registered outputs track it exactly.
   always_comb begin
      tx_next_s   = 1'b1;
      busy_next_s = 1'b0;
      case (state_next_s)
         ST_START: begin
            tx_next_s   = 1'b0;
            busy_next_s = 1'b1;
         end
         ST_DATA: begin
            tx_next_s   = shift_next_s[idx_next_s];
            busy_next_s = 1'b1;
         end
         ST_STOP: begin
            tx_next_s   = 1'b1;
            busy_next_s = 1'b1;
         end
         default: begin
            tx_next_s   = 1'b1;
            busy_next_s = 1'b0;
         end
      endcase
   end

   // Glitch-free registered serial line and busy flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_r   <= 1'b1;
         busy_r <= 1'b0;
      end else begin
         tx_r   <= tx_next_s;
         busy_r <= busy_next_s;
      end
   end

   assign bus.tx         = tx_r;
   assign bus.busy       = busy_r;
   assign bus.full       = full_r;
   assign bus.fifo_count = count_r;
   assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based frame model checked every cycle, plus directed literal checks.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_tx_fifo_if #(.CNT_W(CW)) bus();

   uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .CNT_W       (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a byte queue and a frame in flight described by its elapsed cycle count.
   logic [7:0] m_q[$];
   int         m_act = 0;
   int         m_t   = 0;
   logic [7:0] m_cur = 8'h00;
   logic       m_ovf = 1'b0;

   function automatic logic m_exp_tx();
      if (m_act == 0) return 1'b1;
      if (m_t < CPB) return 1'b0;
      if (m_t < 9 * CPB) return m_cur[(m_t - CPB) / CPB];
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      int sz;
      if (reset) begin
         m_q.delete();
         m_act = 0;
         m_t   = 0;
         m_ovf = 1'b0;
      end else begin
         sz = m_q.size();
         if (m_act != 0) begin
            m_t++;
            if (m_t == 10 * CPB) m_act = 0;
         end
         if (m_act == 0 && sz != 0) begin
            m_cur = m_q.pop_front();
            m_act = 1;
            m_t   = 0;
         end
         if (bus.wr_en) begin
            if (sz == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(bus.wr_data);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("tx",         bus.tx,         m_exp_tx());
         chk("busy",       bus.busy,       m_act);
         chk("fifo_count", bus.fifo_count, m_q.size());
         chk("full",       bus.full,       m_q.size() == DEPTH);
         chk("overflow",   bus.overflow,   m_ovf);
      end
   end

   // Called at a negedge: the byte lands on the next posedge; returns at the following negedge.
   task automatic push(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'($urandom);
   endtask

   task automatic drain();
      for (int g = 0; g < 2000; g++) begin
         if (!bus.busy && bus.fifo_count == 3'd0) break;
         @(negedge clk);
      end
      chk("drain_idle", (bus.busy || bus.fifo_count != 3'd0), 1'b0);
   endtask

   initial begin
      int   busy_cnt;
      int   nrun;
      int   runs[8];
      logic prev;
      logic b;

      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset.
      repeat (100) @(negedge clk);
      chk("idle_tx", bus.tx, 1'b1);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_count", bus.fifo_count, 3'd0);
      chk("idle_full", bus.full, 1'b0);

      // Single byte 0x55.
      push(8'h55);
      chk("k_tx_still_high", bus.tx, 1'b1);
      chk("k_count", bus.fifo_count, 3'd1);
      chk("k_busy", bus.busy, 1'b0);
      busy_cnt = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (j == 0) chk("k1_count", bus.fifo_count, 3'd0);
         if (j < 40) chk("bits_55", bus.tx, (j / 4) % 2);
         busy_cnt += int'(bus.busy);
      end
      chk("busy_len_55", busy_cnt, 40);

      // Burst of six pushes; the sixth overflows.
      busy_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         if (i == 6) begin
            chk("burst_full", bus.full, 1'b1);
            chk("burst_ovf_pre", bus.overflow, 1'b0);
         end
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(i);
         busy_cnt += int'(bus.busy);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      chk("burst_ovf", bus.overflow, 1'b1);
      chk("burst_full_after", bus.full, 1'b1);
      for (int g = 0; g < 500; g++) begin
         if (!bus.busy) break;
         busy_cnt++;
         @(negedge clk);
      end
      chk("burst_busy_len", busy_cnt, 200);

      // Push exactly on the edge that ends STOP while one byte waits.
      drain();
      push(8'h3C);
      push(8'hC3);
      repeat (39) @(negedge clk);
      push(8'hA3);
      chk("sim_count", bus.fifo_count, 3'd1);
      chk("sim_busy", bus.busy, 1'b1);
      chk("sim_tx", bus.tx, 1'b0);

      // Pattern 0x00 then 0xFF: run lengths 36 low, 4 high, 4 low, 36 high.
      drain();
      push(8'h00);
      push(8'hFF);
      nrun = 0;
      prev = 1'b0;
      for (int k = 0; k < 8; k++) runs[k] = 0;
      for (int j = 0; j < 80; j++) begin
         b = bus.tx;
         if (j == 0) begin
            chk("pat_first", b, 1'b0);
            prev    = b;
            runs[0] = 1;
         end else if (b == prev) begin
            runs[nrun]++;
         end else begin
            if (nrun < 7) nrun++;
            runs[nrun] = 1;
            prev = b;
         end
         @(negedge clk);
      end
      chk("pat_nruns", nrun, 3);
      chk("pat_run0", runs[0], 36);
      chk("pat_run1", runs[1], 4);
      chk("pat_run2", runs[2], 4);
      chk("pat_run3", runs[3], 36);

      // Asynchronous reset during DATA bit 3 of 0xF0.
      drain();
      push(8'hF0);
      repeat (18) @(negedge clk);
      chk("mid_tx_bit3", bus.tx, 1'b0);
      chk("mid_busy", bus.busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_tx", bus.tx, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_count", bus.fifo_count, 3'd0);
      chk("rst_full", bus.full, 1'b0);
      chk("rst_ovf", bus.overflow, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      push(8'h0F);
      repeat (50) @(negedge clk);

      // Randomized traffic at a light and a heavy rate.
      for (int c = 0; c < 3000; c++) begin
         bus.wr_en   = ($urandom_range(0, 99) < ((c < 1500) ? 2 : 13));
         bus.wr_data = 8'($urandom);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
